// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
package period_meter_pkg;

    localparam int          DEFAULT_COUNT_W   = 24;
    localparam logic [23:0] DEFAULT_MAX_COUNT = 24'hFF_FFFF;

    // Measurement FSM states; encoding is visible on the debug port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

endpackage

// File: rtl/period_meter_if.sv
// Bus between the period meter and its user.
//
// Handshake: enable and sig_in flow into the meter. period_valid is a
// one-cycle strobe with no ready/backpressure: period and high_time change
// only in the cycle period_valid is high and hold otherwise, so a consumer
// that misses the strobe can still read the last result. overflow and busy
// are levels. state_dbg mirrors the FSM state for observation only.
interface period_meter_if #(
    parameter int COUNT_W = 24
) ();
    import period_meter_pkg::*;

    logic               enable;
    logic               sig_in;
    logic [COUNT_W-1:0] period;
    logic [COUNT_W-1:0] high_time;
    logic               period_valid;
    logic               overflow;
    logic               busy;
    state_t             state_dbg;

    modport master (
        input  enable, sig_in,
        output period, high_time, period_valid, overflow, busy, state_dbg
    );

    modport slave (
        output enable, sig_in,
        input  period, high_time, period_valid, overflow, busy, state_dbg
    );

endinterface

// File: rtl/period_meter_edge_sync.sv
// Input capture and edge detection for slow lab signals.
// Build option PERIOD_METER_SYNC_EN: when defined, sig_in first passes a
// 2-flop synchronizer (for asynchronous inputs), adding two cycles of latency.
module edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic s_q,
    output logic rise,
    output logic fall
);

    logic cap_d;
    logic s_d;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer ahead of the capture flop.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) sync_q <= 2'b00;
        else      sync_q <= {sync_q[0], sig_in};
    end

    assign cap_d = sync_q[1];
`else
    assign cap_d = sig_in;
`endif

    // Capture flop plus one-cycle delay used for edge comparison.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s_q <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s_q <= cap_d;
            s_d <= s_q;
        end
    end

    assign rise = s_q & ~s_d;
    assign fall = ~s_q & s_d;

endmodule

// File: rtl/period_meter.sv
// Period / high-time meter: counts clk_in cycles between rising edges of a
// slow input. Build option PERIOD_METER_SYNC_EN selects the input synchronizer
// inside edge_sync. MAX_COUNT must lie in [2, 2^COUNT_W-1].
module period_meter
    import period_meter_pkg::*;
#(
    parameter int                 COUNT_W   = DEFAULT_COUNT_W,
    parameter logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(DEFAULT_MAX_COUNT)
) (
    input  logic            clk_in,
    input  logic            rst,
    period_meter_if.master  bus
);

    logic s_q, rise, fall;

    edge_sync u_edge_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (bus.sig_in),
        .s_q    (s_q),
        .rise   (rise),
        .fall   (fall)
    );

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] hcnt_q, hcnt_d;
    logic               hrun_q, hrun_d;
    logic [COUNT_W-1:0] period_q, period_d;
    logic [COUNT_W-1:0] high_q, high_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;

    // State, counters and result registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            hrun_q   <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            hrun_q   <= hrun_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next state: enable low always wins; a rise outranks the count limit so
    // a period of exactly MAX_COUNT is still reported. hrun stops high-time
    // counting at the falling edge until the next rise.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        hrun_d   = hrun_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;

        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            hrun_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        cnt_d   = COUNT_W'(1);
                        hcnt_d  = COUNT_W'(1);
                        hrun_d  = 1'b1;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        ovf_d    = 1'b0;
                        cnt_d    = COUNT_W'(1);
                        hcnt_d   = COUNT_W'(1);
                        hrun_d   = 1'b1;
                    end else if (cnt_q == MAX_COUNT) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                        hrun_d  = 1'b0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (fall) hrun_d = 1'b0;
                        if (s_q && hrun_q) hcnt_d = hcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.period       = period_q;
    assign bus.high_time    = high_q;
    assign bus.period_valid = valid_q;
    assign bus.overflow     = ovf_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed waveforms plus random
// high/low segments, compared every cycle against a rise-timestamp model.
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int CW   = 16;
    localparam int MAXC = 100;

    logic clk_in = 1'b0;
    logic rst;

    always #5 clk_in = ~clk_in;

    period_meter_if #(.COUNT_W(CW)) bus ();

    period_meter #(.COUNT_W(CW), .MAX_COUNT(CW'(MAXC))) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Model: sampled sig_in history and the edge index of the reference rise.
    logic            hist[$];
    bit              m_on  = 1'b0;
    int              m_ref = -1;
    int              e_period = 0;
    int              e_high   = 0;
    bit              e_ovf    = 1'b0;
    bit              e_valid  = 1'b0;
    logic [2*CW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge.
    task automatic model_edge(input logic en, input logic s, input logic rs);
        int  m;
        int  ones;
        bit  rise_prev;
        e_valid = 1'b0;
        if (!rs) begin
            hist.push_back(1'b0);
            m_on = 1'b0; m_ref = -1;
            e_period = 0; e_high = 0; e_ovf = 1'b0;
            return;
        end
        hist.push_back(s);
        m = hist.size() - 1;
        rise_prev = (m >= 2) && hist[m-1] && !hist[m-2];
        if (!en) begin
            m_on = 1'b0; m_ref = -1;
        end else if (!m_on) begin
            m_on = 1'b1; m_ref = -1;
        end else if (rise_prev) begin
            if (m_ref >= 0) begin
                ones = 0;
                for (int i = m_ref - 1; i <= m - 2; i++) ones += int'(hist[i]);
                e_period = m - m_ref;
                e_high   = ones;
                e_valid  = 1'b1;
                e_ovf    = 1'b0;
                exp_q.push_back({CW'(e_period), CW'(e_high)});
            end
            m_ref = m;
        end else if (m_ref >= 0 && (m - m_ref) == MAXC) begin
            e_ovf = 1'b1;
            m_ref = -1;
        end
    endtask

    task automatic compare();
        int exp_state;
        exp_state = !m_on ? 0 : (m_ref < 0 ? 1 : 2);
        check("period_valid", bus.period_valid, e_valid);
        check("overflow", bus.overflow, e_ovf);
        check("busy", bus.busy, m_on);
        check("state", bus.state_dbg, exp_state);
        check("period", bus.period, e_period);
        check("high_time", bus.high_time, e_high);
        if (bus.period_valid === 1'b1) begin
            if (exp_q.size() == 0) check("sb_unexpected_strobe", exp_q.size(), 1);
            else check("sb_result", {bus.period, bus.high_time}, exp_q.pop_front());
        end
    endtask

    // Drive one cycle from a negedge, model the posedge, compare at negedge.
    task automatic tick(input logic en, input logic s);
        bus.enable = en;
        bus.sig_in = s;
        @(posedge clk_in);
        model_edge(en, s, rst);
        @(negedge clk_in);
        compare();
    endtask

    // Periodic wave; enable is low for cycles in [dis_from, dis_to).
    task automatic run_pattern(input int hi, input int lo, input int ncyc,
                               input int dis_from, input int dis_to);
        for (int c = 0; c < ncyc; c++) begin
            tick(!(c >= dis_from && c < dis_to), (c % (hi + lo)) < hi);
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.sig_in = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 compare();
        repeat (3) tick(1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) tick(1'b0, 1'b0);

        run_pattern(4, 4, 80, -1, -1);      // divider loopback: period 8, high 4
        run_pattern(3, 7, 60, -1, -1);      // period 10, high 3
        run_pattern(2, 200, 202, -1, -1);   // stuck low after a rise: overflow
        run_pattern(10, 10, 100, -1, -1);   // recovery with period 20
        run_pattern(50, 50, 400, -1, -1);   // period exactly MAX_COUNT
        run_pattern(40, 61, 303, -1, -1);   // one cycle beyond MAX_COUNT
        tick(1'b1, 1'b1);                   // one full-scale period after overflow
        run_pattern(1, 1, 40, -1, -1);      // minimum period 2
        run_pattern(5, 7, 120, 30, 36);     // enable dropped mid-period
        repeat (160) tick(1'b1, 1'b1);      // stuck high

        for (int seg = 0; seg < 220; seg++) begin
            int  hi;
            int  lo;
            logic en;
            hi = $urandom_range(1, 12);
            lo = $urandom_range(1, 12);
            if ($urandom_range(0, 19) == 0) lo = $urandom_range(90, 130);
            en = ($urandom_range(0, 15) != 0);
            for (int i = 0; i < hi; i++) tick(en, 1'b1);
            for (int i = 0; i < lo; i++) tick(en, 1'b0);
        end

        // Asynchronous reset between clock edges while measuring.
        run_pattern(6, 6, 30, -1, -1);
        #2 rst = 1'b0;
        #1;
        check("rst_period", bus.period, 0);
        check("rst_high_time", bus.high_time, 0);
        check("rst_valid", bus.period_valid, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk_in);
        model_edge(1'b1, bus.sig_in, rst);
        @(negedge clk_in);
        compare();
        for (int c = 0; c < 3; c++) tick(1'b1, c[0]);
        rst = 1'b1;
        run_pattern(6, 6, 60, -1, -1);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the clock-divider output from the other end: takes a slow square wave and recovers its period and high time as clk_in cycle counts.
- Used in lab bring-up to check divider outputs, and to measure any slow external signal against the board clock.
- Continuous rising-edge-to-rising-edge measurement.
- Each completed period produces a one-cycle valid strobe; over-long periods raise a sticky overflow flag.

Parameters:
- COUNT_W, 24, width of the period/high-time counters and outputs.
- MAX_COUNT, 24'hFF_FFFF, largest reportable period; must be at most 2^COUNT_W-1 and at least 2.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- sig_in  input  1  signal under measurement (square wave, e.g. a divider clk_out).
- period  output  COUNT_W  last complete period in clk_in cycles.
- high_time  output  COUNT_W  clk_in cycles sig_in was high in that period.
- period_valid  output  1  one-cycle strobe; period/high_time updated this cycle.
- overflow  output  1  sticky: no rising edge within MAX_COUNT cycles.
- busy  output  1  high in ARM and MEASURE.

Behaviour:
- Reset (rst=0, asynchronous): period=0, high_time=0, period_valid=0, overflow=0, busy=0, state=IDLE, counters=0, edge-detect flops=0.
- Edge detect:
  - s_q = sig_in registered; s_d = s_q delayed one cycle.
  - rise = s_q & ~s_d; fall = ~s_q & s_d.
- States:
  - IDLE: busy=0. enable=1 -> ARM.
  - ARM: wait for rise. On rise: cnt<=1, hcnt<=1 -> MEASURE. No output update.
  - MEASURE:
    - Each cycle: cnt<=cnt+1; hcnt<=hcnt+1 while s_q=1.
    - On fall: hcnt freezes.
    - On rise: period<=cnt, high_time<=hcnt, period_valid<=1 (next cycle only), overflow<=0, cnt<=1, hcnt<=1; stay MEASURE.
- Result: a sig_in of period N and high time H yields period=N, high_time=H.
- Latency: period_valid asserts 2 clk_in cycles after the first clk_in edge that samples sig_in high.
- Overflow:
  - In MEASURE with cnt==MAX_COUNT and no rise: overflow<=1 -> ARM.
  - period, high_time and period_valid are not updated.
  - Rise in the same cycle as cnt==MAX_COUNT: the rise wins and period=MAX_COUNT is reported normally.
- enable deassert in any state:
  - -> IDLE next cycle; counters cleared.
  - period, high_time and overflow hold.
  - A pending rise that cycle is discarded.
- enable reasserted: -> ARM. The first partial period is never reported.
- sig_in stuck high or low: overflow after MAX_COUNT cycles, then wait in ARM; no valid strobes.
- Minimum measurable period is 2 (alternate-cycle toggle). Shorter pulses are not guaranteed.
- Counters never wrap: cnt is capped by the MAX_COUNT check.
- Reset mid-measurement: immediate return to reset values; no strobe.

Optional Feature:
- PERIOD_METER_SYNC_EN:
  - Defined: sig_in passes a 2-flop synchronizer before s_q; latency becomes 4 cycles; measured values unchanged; use for asynchronous/external sig_in.
  - Undefined: sig_in must be synchronous to clk_in; single capture flop; latency 2.

Decomposition:
- Shared package period_meter_pkg:
  - state enum with IDLE=2'd0, ARM=2'd1, MEASURE=2'd2.
  - default COUNT_W and MAX_COUNT constants.
- One natural sub-module, edge_sync: optional synchronizer + capture + rise/fall detect. Reusable by other lab input blocks.
- The FSM and counters stay in period_meter.

Test Plan:
- Loopback from clkdivider FINAL_COUNT=3 (toggles every 4 cycles), enable=1 -> first valid after 1 full period, then every 8 cycles: period=8, high_time=4, overflow=0.
- sig_in high 3 cycles, low 7 cycles, repeating -> period=10, high_time=3 on every strobe; strobe spacing exactly 10 cycles.
- MAX_COUNT=100, sig_in held low after one rise -> overflow=1 at cycle 100 after that rise, no strobe. Then periodic sig_in of period 20 -> next valid gives period=20, overflow=0.
- Rise exactly at cnt==MAX_COUNT (MAX_COUNT=50, period 50) -> period=50, period_valid=1, overflow stays 0.
- enable dropped mid-period -> busy=0 next cycle, period holds its old value. Re-enable -> first strobe only after a full period, correct value.
- rst=0 asserted asynchronously between clock edges mid-MEASURE -> all outputs 0 immediately. Release -> IDLE, no spurious strobe.
